// File: rtl/pulse_stretcher_pkg.sv
// Shared state encodings, default timing constants and counter sizing for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_HIGH_CYCLES = 10;
  localparam int DEF_GAP_CYCLES  = 2;
  localparam int DEF_PEND_W      = 4;

  // Bits needed to hold max(high, gap) - 1, never less than one bit.
  function automatic int cnt_w(input int high_cycles, input int gap_cycles);
    int m;
    m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_stretcher_edge_detect.sv
// Rising-edge detector; the history register resets high so a level held through reset is not an event.
module pulse_stretcher_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic trig
);

  logic din_d;

  always_ff @(posedge clk_in) begin
    if (rst) din_d <= 1'b1;
    else     din_d <= din;
  end

  assign trig = din & ~din_d;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HIGH_CYCLES-wide pulses separated by GAP_CYCLES lows,
// queueing events that arrive while busy and replaying them in order.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int PEND_W      = DEF_PEND_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              din,
  output logic              dout,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int CW = cnt_w(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt, dout_nxt, busy_nxt;
  logic              trig;

  pulse_stretcher_edge_detect u_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (din),
    .trig   (trig)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pend_cnt <= '0;
      overflow <= 1'b0;
      dout     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend_cnt <= pend_nxt;
      overflow <= ovf_nxt;
      dout     <= dout_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend_cnt;
    ovf_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (cnt == '0) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
        if (trig) begin
          if (pend_cnt != PEND_MAX) pend_nxt = pend_cnt + PEND_W'(1);
          else                      ovf_nxt  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          // A trig on the final gap cycle either offsets the dequeue or starts the next pulse directly.
          if (pend_cnt != '0) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = HIGH_LOAD;
            if (!trig) pend_nxt = pend_cnt - PEND_W'(1);
          end else if (trig) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = HIGH_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
          if (trig) begin
            if (pend_cnt != PEND_MAX) pend_nxt = pend_cnt + PEND_W'(1);
            else                      ovf_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    dout_nxt = (state_nxt == ST_HIGH);
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: a timeline model of pulse start times predicts every cycle's outputs.
module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  typedef struct {
    bit dout;
    bit busy;
    bit ovf;
    int pend;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic          din    = 1'b0;
  logic          dout, busy, overflow;
  logic [PW-1:0] pend_cnt;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // model state: start edge of the current pulse, pending events, last sampled din
  int t = 0;
  int s = 0;
  bit active = 0;
  int pend = 0;
  bit prev = 1;
  bit m_ovf = 0;

  pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .din      (din),
    .dout     (dout),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  always #5 clk_in = ~clk_in;

  // Drive inputs for the next rising edge and predict the outputs registered at it.
  task automatic step(input bit r, input bit d);
    bit   trig;
    exp_t e;
    @(negedge clk_in);
    rst = r;
    din = d;
    trig = d && !prev;
    m_ovf = 0;
    if (r) begin
      active = 0;
      pend   = 0;
      prev   = 1;
    end else begin
      prev = d;
      if (!active || t >= s + H + G) begin
        if (pend > 0) begin
          s = t; active = 1; pend--;
          if (trig) pend++;
        end else if (trig) begin
          s = t; active = 1;
        end else begin
          active = 0;
        end
      end else if (trig) begin
        if (pend < PMAX) pend++;
        else m_ovf = 1;
      end
    end
    e.dout = active && (t < s + H);
    e.busy = active;
    e.ovf  = m_ovf;
    e.pend = pend;
    exp_q.push_back(e);
    t++;
  endtask

  task automatic hold(input bit d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, d);
  endtask

  always @(posedge clk_in) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 4;
      if (dout !== e.dout) begin
        failures++;
        $display("FAIL dout t=%0t got=%b want=%b", $time, dout, e.dout);
      end
      if (busy !== e.busy) begin
        failures++;
        $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy);
      end
      if (overflow !== e.ovf) begin
        failures++;
        $display("FAIL overflow t=%0t got=%b want=%b", $time, overflow, e.ovf);
      end
      if (pend_cnt !== PW'(e.pend)) begin
        failures++;
        $display("FAIL pend_cnt t=%0t got=%0d want=%0d", $time, pend_cnt, e.pend);
      end
    end
  end

  initial begin
    int mode;
    int wait_cyc;
    // reset, then a single pulse and a long level
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    hold(0, 4); hold(1, 1); hold(0, 12);
    hold(1, 12); hold(0, 10);
    // burst of three pulses two cycles apart
    for (int i = 0; i < 3; i++) begin hold(1, 1); hold(0, 1); end
    hold(0, 20);
    // dense pulses to saturate the queue
    for (int i = 0; i < 8; i++) begin hold(1, 1); hold(0, 1); end
    hold(0, 40);
    // reset mid-pulse with din held high through release
    hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 1);
    hold(1, 1);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    hold(1, 8); hold(0, 2); hold(1, 1); hold(0, 12);
    // randomized segments
    for (int seg = 0; seg < 300; seg++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: for (int i = 0; i < 10; i++) step(1'b0, ($urandom_range(0, 9) == 0));
        1: for (int i = 0; i < 10; i++) step(1'b0, ($urandom_range(0, 1) == 0));
        2: begin
          hold(1, $urandom_range(1, 15));
          hold(0, $urandom_range(1, 4));
        end
        3: begin
          for (int i = 0; i < $urandom_range(1, 2); i++) step(1'b1, $urandom_range(0, 1) == 1);
        end
        default: begin
          for (int i = 0; i < 6; i++) begin
            hold(1, 1); hold(0, $urandom_range(1, 2));
          end
        end
      endcase
    end
    hold(0, 40);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk_in);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
